// File: rtl/sfx_tone_driver.sv
`default_nettype none
// ============================================================================
// Module   : sfx_tone_driver
// Brief    : Turns one-shot jump/death game events into square-wave buzzer tone
//            bursts; note lengths in frame ticks, pitch in clk cycles.
// Config   : SFX_SCORE_CHIME_EN adds the score_trig input and a CHIME note.
// Revision : 1.0 - initial release
// ============================================================================
module sfx_tone_driver #(
    parameter int HALF_W      = 8,
    parameter int JUMP_HALF   = 50,
    parameter int DIE_HALF_A  = 120,
    parameter int DIE_HALF_B  = 200,
    parameter int JUMP_TICKS  = 6,
    parameter int DIE_TICKS   = 15
`ifdef SFX_SCORE_CHIME_EN
   ,parameter int CHIME_HALF  = 30,
    parameter int CHIME_TICKS = 3
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic jump_trig,
    input  logic die_trig,
`ifdef SFX_SCORE_CHIME_EN
    input  logic score_trig,
`endif
    input  logic mute,
    output logic audio_out,
    output logic busy
);

`ifdef SFX_SCORE_CHIME_EN
    localparam int c_SW = 3;
`else
    localparam int c_SW = 2;
`endif

    localparam logic [c_SW-1:0] c_IDLE  = c_SW'(0);
    localparam logic [c_SW-1:0] c_JUMP  = c_SW'(1);
    localparam logic [c_SW-1:0] c_DIE_A = c_SW'(2);
    localparam logic [c_SW-1:0] c_DIE_B = c_SW'(3);
`ifdef SFX_SCORE_CHIME_EN
    localparam logic [c_SW-1:0] c_CHIME = c_SW'(4);
`endif

    localparam logic [3:0]        c_JUMP_TICKS = 4'(JUMP_TICKS);
    localparam logic [3:0]        c_DIE_TICKS  = 4'(DIE_TICKS);
    localparam logic [HALF_W-1:0] c_JUMP_HM1   = HALF_W'(JUMP_HALF - 1);
    localparam logic [HALF_W-1:0] c_DIE_A_HM1  = HALF_W'(DIE_HALF_A - 1);
    localparam logic [HALF_W-1:0] c_DIE_B_HM1  = HALF_W'(DIE_HALF_B - 1);
`ifdef SFX_SCORE_CHIME_EN
    localparam logic [3:0]        c_CHIME_TICKS = 4'(CHIME_TICKS);
    localparam logic [HALF_W-1:0] c_CHIME_HM1   = HALF_W'(CHIME_HALF - 1);
`endif

    logic [c_SW-1:0]   r_state;
    logic [c_SW-1:0]   w_state_nxt;
    logic [3:0]        r_dur;
    logic [3:0]        w_dur_nxt;
    logic [HALF_W-1:0] r_half_cnt;
    logic [HALF_W-1:0] w_half_nxt;
    logic [HALF_W-1:0] w_half_m1;
    logic              r_tone;
    logic              w_tone_nxt;
    logic              w_entry;
    logic              w_active_nxt;
    logic              r_jump_q;
    logic              r_die_q;
    logic              r_busy;
    logic              r_audio;
    logic              w_rise_jump;
    logic              w_rise_die;
`ifdef SFX_SCORE_CHIME_EN
    logic              r_score_q;
    logic              w_rise_score;
    assign w_rise_score = score_trig & ~r_score_q;
`endif

    assign w_rise_jump  = jump_trig & ~r_jump_q;
    assign w_rise_die   = die_trig & ~r_die_q;
    assign w_active_nxt = (w_state_nxt != c_IDLE);
    assign busy         = r_busy;
    assign audio_out    = r_audio;

    // A trigger always beats a tick in the same cycle, so a fresh note gets its full length.
    always_comb begin
        w_state_nxt = r_state;
        w_dur_nxt   = r_dur;
        w_entry     = 1'b0;
        if (w_rise_die) begin
            w_state_nxt = c_DIE_A;
            w_dur_nxt   = c_DIE_TICKS;
            w_entry     = 1'b1;
        end else if (w_rise_jump && (r_state == c_IDLE || r_state == c_JUMP)) begin
            w_state_nxt = c_JUMP;
            w_dur_nxt   = c_JUMP_TICKS;
            w_entry     = 1'b1;
`ifdef SFX_SCORE_CHIME_EN
        end else if (w_rise_score && (r_state == c_IDLE || r_state == c_CHIME)) begin
            w_state_nxt = c_CHIME;
            w_dur_nxt   = c_CHIME_TICKS;
            w_entry     = 1'b1;
`endif
        end else if (tick_en && r_state != c_IDLE) begin
            if (r_dur == 4'd1) begin
                if (r_state == c_DIE_A) begin
                    w_state_nxt = c_DIE_B;
                    w_dur_nxt   = c_DIE_TICKS;
                    w_entry     = 1'b1;
                end else begin
                    w_state_nxt = c_IDLE;
                    w_dur_nxt   = 4'd0;
                end
            end else begin
                w_dur_nxt = r_dur - 4'd1;
            end
        end
    end

    always_comb begin
        w_half_m1 = '0;
        case (w_state_nxt)
            c_JUMP:  w_half_m1 = c_JUMP_HM1;
            c_DIE_A: w_half_m1 = c_DIE_A_HM1;
            c_DIE_B: w_half_m1 = c_DIE_B_HM1;
`ifdef SFX_SCORE_CHIME_EN
            c_CHIME: w_half_m1 = c_CHIME_HM1;
`endif
            default: w_half_m1 = '0;
        endcase
    end

    // Every note starts low with a full half-period, giving a clean phase on retrigger.
    always_comb begin
        w_tone_nxt = r_tone;
        w_half_nxt = r_half_cnt;
        if (!w_active_nxt) begin
            w_tone_nxt = 1'b0;
            w_half_nxt = '0;
        end else if (w_entry) begin
            w_tone_nxt = 1'b0;
            w_half_nxt = w_half_m1;
        end else if (r_half_cnt == '0) begin
            w_tone_nxt = ~r_tone;
            w_half_nxt = w_half_m1;
        end else begin
            w_half_nxt = r_half_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_dur      <= 4'd0;
            r_half_cnt <= '0;
            r_tone     <= 1'b0;
            r_jump_q   <= 1'b0;
            r_die_q    <= 1'b0;
`ifdef SFX_SCORE_CHIME_EN
            r_score_q  <= 1'b0;
`endif
            r_busy     <= 1'b0;
            r_audio    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dur      <= w_dur_nxt;
            r_half_cnt <= w_half_nxt;
            r_tone     <= w_tone_nxt;
            r_jump_q   <= jump_trig;
            r_die_q    <= die_trig;
`ifdef SFX_SCORE_CHIME_EN
            r_score_q  <= score_trig;
`endif
            r_busy     <= w_active_nxt;
            r_audio    <= w_tone_nxt & w_active_nxt & ~mute;
        end
    end

endmodule
`default_nettype wire
